recfg_tile_sched: RTL
=====================

Name: recfg_tile_sched

Overview:
Tile-level sequencer for recfg_array. Walks row-block/column-block loops for a MAC job (mode 000) or a row-block loop for element-wise jobs (modes 001/010/011). Per tile it requests operand staging, drives valid_in, accumulate_en and mode, waits for done_tile, then issues a write-back strobe. Sits between the layer controller (start/done) and the array plus its operand/psum buffers.

Parameters:
TILE_SIZE, 16, array edge; number of valid_in cycles per MAC tile
CNT_W, 8, width of block counters and of n_rowblk/n_colblk
TMO_W, 8, watchdog width; timeout fires after 2**TMO_W-1 WAIT cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
abort  in  1  synchronous abort of the running job
cfg_mode  in  3  job mode, latched on accepted start
cfg_n_rowblk  in  CNT_W  row-block count, latched on start
cfg_n_colblk  in  CNT_W  column-block count (MAC only), latched on start
busy  out  1  high from the cycle after accepted start until DONE exits
done  out  1  one-cycle pulse at job end
err_code  out  2  sticky: 0 none, 1 illegal mode, 2 timeout, 3 spurious done_tile
tile_req  out  1  operand staging request for (tile_rb, tile_cb)
tile_ack  in  1  operands and acc_in_vec are loaded
tile_rb  out  CNT_W  current row block
tile_cb  out  CNT_W  current column block
arr_mode  out  3  to array mode
arr_valid_in  out  1  to array valid_in
arr_accumulate_en  out  1  to array accumulate_en
arr_done_tile  in  1  from array done_tile
wb_en  out  1  one-cycle strobe: capture result_out_* for (tile_rb, tile_cb)
wb_final  out  1  qualifies wb_en: this is the final result for tile_rb

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, err_code 0.
- States: IDLE, FETCH, ISSUE, WAIT, WB, DONE.
- IDLE: start=1 -> latch cfg, clear err_code, rb=cb=0, busy=1 next cycle. Next state:
  - FETCH normally;
  - DONE if either count is 0 (no tile issued);
  - DONE with err_code=1 if cfg_mode >= 3'b100.
- Eff_colblk = cfg_n_colblk for mode 000; 1 for 001/010/011.
- FETCH: tile_req=1 until tile_ack is sampled high. The ack cycle is the last FETCH cycle; next state ISSUE.
- ISSUE: arr_valid_in=1 for exactly TILE_SIZE cycles (mode 000) or 1 cycle (other modes); then WAIT.
- arr_mode = latched mode whenever busy.
- arr_accumulate_en = (mode==000 && cb!=0), held stable from FETCH through WB.
- WAIT: arr_done_tile=1 -> WB. Watchdog counts WAIT cycles; on reaching 2**TMO_W-1 -> err_code=2, state DONE.
- WB (one cycle): wb_en=1; wb_final=(cb==eff_colblk-1). At the end of the cycle advance cb (wrap to 0, rb++). If rb and cb were both last -> DONE, else FETCH.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- arr_done_tile in any state other than WAIT: ignored for sequencing; err_code=3 if err_code is still 0.
- abort=1 in any non-IDLE state: next cycle IDLE, all strobes 0, busy=0, no done pulse. err_code is unchanged.
- start while busy: ignored.
- Async reset mid-job: immediate return to reset values.
- tile_rb/tile_cb are valid FETCH..WB and hold their last value otherwise.
- Min per-tile overhead: FETCH(1)+WAIT(≥1)+WB(1).

Decomposition:
- Package recfg_pkg:
  - mode enum (MODE_MAC=3'b000, MODE_EWM_MAT=3'b001, MODE_EWM_VEC=3'b010, MODE_EWM_OUTER=3'b011);
  - sched_state_t enum;
  - err_code constants;
  - TILE_SIZE default.
- One sub-module, recfg_blk_counter: 2-D rb/cb counter with load/step, last_cb/last_all flags.
- Watchdog and issue counter stay inline.

Test Plan:
- MAC, n_rowblk=3, n_colblk=16, tile_ack 1 cycle after req, done_tile 4 cycles after last valid ->
  - 48 tiles, 768 arr_valid_in cycles;
  - accumulate_en=0 exactly on the 3 tiles with cb=0;
  - 48 wb_en, 3 with wb_final (rb=0,1,2, cb=15);
  - one done pulse.
- Mode 001, n_rowblk=16, n_colblk=9 ->
  - cb stays 0;
  - 16 single-cycle valid_in pulses;
  - accumulate_en always 0;
  - 16 wb_en all with wb_final;
  - err_code=0.
- Mode 3'b101 start -> no tile_req, done pulse within 2 cycles, err_code=1. Next legal start clears err_code to 0.
- MAC job with done_tile withheld at tile (0,2) -> after 255 WAIT cycles err_code=2, done pulse, busy falls.
- abort asserted during ISSUE of tile (1,5) -> next cycle arr_valid_in=0, busy=0, no done. A following start runs a full job from (0,0).
- n_colblk=0 start -> zero tile_req, done pulse. Extra start pulses during a busy MAC job and a done_tile injected in FETCH -> job result unchanged, err_code=3.

Source files
------------

// File: rtl/recfg_pkg.sv
// Shared types and constants for the recfg_array tile scheduler.
//   mode_t        : array operating modes (MAC and element-wise variants)
//   sched_state_t : tile scheduler FSM states
//   ERR_*         : err_code encodings
//   TILE_SIZE_DEF : default array edge length
package recfg_pkg;

    typedef enum logic [2:0] {
        MODE_MAC       = 3'b000,
        MODE_EWM_MAT   = 3'b001,
        MODE_EWM_VEC   = 3'b010,
        MODE_EWM_OUTER = 3'b011
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } sched_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_MODE = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_SPUR = 2'd3;

    localparam int TILE_SIZE_DEF = 16;

endpackage

// File: rtl/recfg_blk_counter.sv
// 2-D row-block / column-block counter for the tile scheduler.
//   load     : clear rb and cb to 0
//   step     : advance cb; on the last cb wrap to 0 and advance rb
//   n_rb/n_cb: loop bounds (must be non-zero while stepping)
//   rb/cb    : current block indices
//   last_cb  : cb is the final column block
//   last_all : both rb and cb are at their final block
module recfg_blk_counter
    import recfg_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [CNT_W-1:0] n_rb,
    input  logic [CNT_W-1:0] n_cb,
    output logic [CNT_W-1:0] rb,
    output logic [CNT_W-1:0] cb,
    output logic             last_cb,
    output logic             last_all
);

    logic [CNT_W-1:0] rb_q, rb_d;
    logic [CNT_W-1:0] cb_q, cb_d;

    assign rb       = rb_q;
    assign cb       = cb_q;
    assign last_cb  = (cb_q == n_cb - 1'b1);
    assign last_all = last_cb && (rb_q == n_rb - 1'b1);

    always_comb begin
        rb_d = rb_q;
        cb_d = cb_q;
        if (load) begin
            rb_d = '0;
            cb_d = '0;
        end else if (step) begin
            if (last_cb) begin
                cb_d = '0;
                rb_d = rb_q + 1'b1;
            end else begin
                cb_d = cb_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_q <= '0;
            cb_q <= '0;
        end else begin
            rb_q <= rb_d;
            cb_q <= cb_d;
        end
    end

endmodule

// File: rtl/recfg_tile_sched.sv
// Tile-level sequencer for recfg_array. Walks the rb/cb tile loops of a job,
// requests operand staging per tile, streams valid_in into the array, waits
// for done_tile and emits a write-back strobe.
//   start/abort/cfg_*  : job control from the layer controller
//   busy/done/err_code : job status (err_code is sticky until next start)
//   tile_req/tile_ack  : operand staging handshake for (tile_rb, tile_cb)
//   arr_*              : array control; arr_done_tile returns tile completion
//   wb_en/wb_final     : result capture strobe and final-result qualifier
module recfg_tile_sched
    import recfg_pkg::*;
#(
    parameter int TILE_SIZE = TILE_SIZE_DEF,
    parameter int CNT_W     = 8,
    parameter int TMO_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_n_rowblk,
    input  logic [CNT_W-1:0] cfg_n_colblk,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err_code,
    output logic             tile_req,
    input  logic             tile_ack,
    output logic [CNT_W-1:0] tile_rb,
    output logic [CNT_W-1:0] tile_cb,
    output logic [2:0]       arr_mode,
    output logic             arr_valid_in,
    output logic             arr_accumulate_en,
    input  logic             arr_done_tile,
    output logic             wb_en,
    output logic             wb_final
);

    localparam int ISS_W = $clog2(TILE_SIZE) + 1;
    localparam logic [ISS_W-1:0] ISS_LAST_MAC = ISS_W'(TILE_SIZE - 1);
    // Compare value for the watchdog: WAIT cycle number 2**TMO_W-1 is the last.
    localparam logic [TMO_W-1:0] WD_LAST = TMO_W'((2 ** TMO_W) - 2);

    sched_state_t     state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] n_rb_q, n_rb_d;
    logic [CNT_W-1:0] n_cb_q, n_cb_d;
    logic [1:0]       err_q, err_d;
    logic [ISS_W-1:0] iss_q, iss_d;
    logic [TMO_W-1:0] wd_q, wd_d;

    logic             cnt_load, cnt_step;
    logic             last_cb, last_all;
    logic [CNT_W-1:0] rb, cb;
    logic [CNT_W-1:0] eff_colblk;
    logic [ISS_W-1:0] iss_last;
    logic             in_tile;

    // Element-wise jobs walk a single column block.
    assign eff_colblk = (cfg_mode == MODE_MAC) ? cfg_n_colblk : CNT_W'(1);
    assign iss_last   = (mode_q == MODE_MAC) ? ISS_LAST_MAC : '0;
    assign in_tile    = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                        (state_q == S_WAIT)  || (state_q == S_WB);

    recfg_blk_counter #(.CNT_W(CNT_W)) u_blk_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .step     (cnt_step),
        .n_rb     (n_rb_q),
        .n_cb     (n_cb_q),
        .rb       (rb),
        .cb       (cb),
        .last_cb  (last_cb),
        .last_all (last_all)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        n_rb_d   = n_rb_q;
        n_cb_d   = n_cb_q;
        err_d    = err_q;
        iss_d    = iss_q;
        wd_d     = wd_q;
        cnt_load = 1'b0;
        cnt_step = 1'b0;

        // done_tile outside WAIT never moves the FSM; it only flags an error.
        if (arr_done_tile && (state_q != S_WAIT) && (err_q == ERR_NONE)) begin
            err_d = ERR_SPUR;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = cfg_mode;
                    n_rb_d   = cfg_n_rowblk;
                    n_cb_d   = eff_colblk;
                    err_d    = ERR_NONE;
                    cnt_load = 1'b1;
                    if (cfg_mode[2]) begin
                        err_d   = ERR_MODE;
                        state_d = S_DONE;
                    end else if ((cfg_n_rowblk == '0) || (eff_colblk == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (tile_ack) begin
                    iss_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (iss_q == iss_last) begin
                    wd_d    = '0;
                    state_d = S_WAIT;
                end else begin
                    iss_d = iss_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (arr_done_tile) begin
                    state_d = S_WB;
                end else if (wd_q == WD_LAST) begin
                    err_d   = ERR_TMO;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_WB: begin
                // The final tile is not stepped so tile_rb/tile_cb hold it.
                if (last_all) begin
                    state_d = S_DONE;
                end else begin
                    cnt_step = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            cnt_step = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            n_rb_q  <= '0;
            n_cb_q  <= '0;
            err_q   <= ERR_NONE;
            iss_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            n_rb_q  <= n_rb_d;
            n_cb_q  <= n_cb_d;
            err_q   <= err_d;
            iss_q   <= iss_d;
            wd_q    <= wd_d;
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);
    assign err_code          = err_q;
    assign tile_req          = (state_q == S_FETCH);
    assign tile_rb           = rb;
    assign tile_cb           = cb;
    assign arr_mode          = busy ? mode_q : 3'b000;
    assign arr_valid_in      = (state_q == S_ISSUE);
    assign arr_accumulate_en = in_tile && (mode_q == MODE_MAC) && (cb != '0);
    assign wb_en             = (state_q == S_WB);
    assign wb_final          = (state_q == S_WB) && last_cb;

endmodule
